// File: rtl/render_cmd_sequencer_pkg.sv
// Shared types for the render command sequencer: command opcodes, vertex/colour
// formats and the sequencer state encoding.
package render_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        CMD_DRAW  = 2'd0,
        CMD_CLEAR = 2'd1,
        CMD_FENCE = 2'd2,
        CMD_NOP   = 2'd3
    } render_cmd_t;

    localparam int CLR_MASK_COLOR = 0;
    localparam int CLR_MASK_DEPTH = 1;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vertex_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRI,
        S_DRAIN,
        S_CLR_ISSUE,
        S_CLR_WAIT,
        S_FENCE
    } seq_state_t;

    // True once every target selected by mask has been observed clearing.
    function automatic logic targets_seen(input logic [1:0] mask, input logic [1:0] seen);
        return &(seen | ~mask);
    endfunction

endpackage

// File: rtl/render_cmd_sequencer_if.sv
// Command-side and rasterizer-side bus of the render command sequencer.
// master = command source / rasterizer side, slave = the sequencer.
interface render_cmd_sequencer_if #(
    parameter int CNT_W = 16
) ();
    import render_cmd_sequencer_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    render_cmd_t cmd_op;
    vertex_t     cmd_v0, cmd_v1, cmd_v2;
    logic [1:0]  cmd_clear_mask;
    rgb565_t     cmd_clear_color;
    logic [15:0] cmd_clear_depth;

    vertex_t     tri_v0, tri_v1, tri_v2;
    logic        tri_valid;
    logic        tri_ready;
    logic        rast_busy;
    logic        frag_valid;

    logic        fb_clear;
    rgb565_t     fb_clear_color;
    logic        fb_clearing;
    logic        depth_clear;
    logic [15:0] depth_clear_value;
    logic        depth_clearing;

    logic             fence_done;
    logic [CNT_W-1:0] tri_count;
    logic             idle;

    modport master (
        output cmd_valid, cmd_op, cmd_v0, cmd_v1, cmd_v2, cmd_clear_mask,
               cmd_clear_color, cmd_clear_depth, tri_ready, rast_busy, frag_valid,
               fb_clearing, depth_clearing,
        input  cmd_ready, tri_v0, tri_v1, tri_v2, tri_valid, fb_clear, fb_clear_color,
               depth_clear, depth_clear_value, fence_done, tri_count, idle
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_v0, cmd_v1, cmd_v2, cmd_clear_mask,
               cmd_clear_color, cmd_clear_depth, tri_ready, rast_busy, frag_valid,
               fb_clearing, depth_clearing,
        output cmd_ready, tri_v0, tri_v1, tri_v2, tri_valid, fb_clear, fb_clear_color,
               depth_clear, depth_clear_value, fence_done, tri_count, idle
    );

endinterface

// File: rtl/render_cmd_sequencer_drain.sv
// Quiet-cycle counter: drained_o rises the cycle after DRAIN_CYCLES consecutive
// quiet cycles have been seen while enabled; start_i restarts the count.
module pipe_drain_detect #(
    parameter int DRAIN_CYCLES = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic en_i,
    input  logic busy_i,
    output logic drained_o
);
    localparam int W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(DRAIN_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         drained_q, drained_d;

    // The count saturates at LAST so a quiet pipeline keeps reporting drained.
    always_comb begin
        cnt_d     = cnt_q;
        drained_d = 1'b0;
        if (start_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (busy_i)             cnt_d = '0;
            else if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
            drained_d = !busy_i && (cnt_q == LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            drained_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            drained_q <= drained_d;
        end
    end

    assign drained_o = drained_q;

endmodule

// File: rtl/render_cmd_sequencer.sv
// Render command front end: runs one command at a time onto the rasterizer,
// holding clears and fences until earlier fragments have drained.
module render_cmd_sequencer
    import render_cmd_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES = 32,
    parameter int CNT_W        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    render_cmd_sequencer_if.slave bus
);
    seq_state_t       state_q, state_d;
    render_cmd_t      op_q;
    vertex_t          v0_q, v1_q, v2_q;
    logic [1:0]       mask_q, seen_q, seen_d;
    rgb565_t          color_q;
    logic [15:0]      depth_q;
    logic [CNT_W-1:0] tri_count_q;

    logic accept, drained, clear_done;
    logic cmd_ready, tri_valid, fb_clear, depth_clear, fence_done, idle;

    assign accept = bus.cmd_valid && (state_q == S_IDLE);

    pipe_drain_detect #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_drain (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (accept),
        .en_i      (state_q == S_DRAIN),
        .busy_i    (bus.rast_busy || bus.frag_valid),
        .drained_o (drained)
    );

    always_comb begin
        seen_d = seen_q;
        if (state_q == S_CLR_ISSUE)     seen_d = '0;
        else if (state_q == S_CLR_WAIT) seen_d = seen_q | {bus.depth_clearing, bus.fb_clearing};
    end

    assign clear_done = targets_seen(mask_q, seen_d) && !bus.fb_clearing && !bus.depth_clearing;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) begin
                case (bus.cmd_op)
                    CMD_DRAW:  state_d = S_TRI;
                    CMD_CLEAR: if (bus.cmd_clear_mask != 2'b00) state_d = S_DRAIN;
                    CMD_FENCE: state_d = S_DRAIN;
                    default:   state_d = S_IDLE;
                endcase
            end
            S_TRI:       if (bus.tri_ready) state_d = S_IDLE;
            S_DRAIN:     if (drained) state_d = (op_q == CMD_FENCE) ? S_FENCE : S_CLR_ISSUE;
            S_CLR_ISSUE: state_d = S_CLR_WAIT;
            S_CLR_WAIT:  if (clear_done) state_d = S_IDLE;
            S_FENCE:     state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        tri_valid   = 1'b0;
        fb_clear    = 1'b0;
        depth_clear = 1'b0;
        fence_done  = 1'b0;
        idle        = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                idle      = 1'b1;
            end
            S_TRI:       tri_valid = 1'b1;
            S_CLR_ISSUE: begin
                fb_clear    = mask_q[CLR_MASK_COLOR];
                depth_clear = mask_q[CLR_MASK_DEPTH];
            end
            S_FENCE:     fence_done = 1'b1;
            default:     ;
        endcase
    end

    // Vertices only move on a new DRAW: triangle setup may sample them late.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q        <= CMD_NOP;
            v0_q        <= '0;
            v1_q        <= '0;
            v2_q        <= '0;
            mask_q      <= '0;
            color_q     <= '0;
            depth_q     <= '0;
            seen_q      <= '0;
            tri_count_q <= '0;
        end else begin
            seen_q <= seen_d;
            if (accept) begin
                op_q <= bus.cmd_op;
                if (bus.cmd_op == CMD_DRAW) begin
                    v0_q <= bus.cmd_v0;
                    v1_q <= bus.cmd_v1;
                    v2_q <= bus.cmd_v2;
                end
                if (bus.cmd_op == CMD_CLEAR && bus.cmd_clear_mask != 2'b00) begin
                    mask_q  <= bus.cmd_clear_mask;
                    color_q <= bus.cmd_clear_color;
                    depth_q <= bus.cmd_clear_depth;
                end
            end
            if (state_q == S_TRI && bus.tri_ready) tri_count_q <= tri_count_q + 1'b1;
        end
    end

    assign bus.cmd_ready         = cmd_ready;
    assign bus.tri_valid         = tri_valid;
    assign bus.tri_v0            = v0_q;
    assign bus.tri_v1            = v1_q;
    assign bus.tri_v2            = v2_q;
    assign bus.fb_clear          = fb_clear;
    assign bus.fb_clear_color    = color_q;
    assign bus.depth_clear       = depth_clear;
    assign bus.depth_clear_value = depth_q;
    assign bus.fence_done        = fence_done;
    assign bus.tri_count         = tri_count_q;
    assign bus.idle              = idle;

endmodule
